// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel counters, registered sync/blank decodes,
// line/frame pulses, and a configurable delayed copy of the sync/blank strobes.
module vga_timing_gen #(
  parameter int PIXEL_DISPLAY_BIT = 9,
  parameter int H_ACTIVE          = 640,
  parameter int H_FP              = 16,
  parameter int H_SYNC            = 96,
  parameter int H_BP              = 48,
  parameter int V_ACTIVE          = 480,
  parameter int V_FP              = 10,
  parameter int V_SYNC            = 2,
  parameter int V_BP              = 33,
  parameter int SYNC_DELAY        = 1
) (
  input  logic                     clock_25,
  input  logic                     reset,
  output logic [PIXEL_DISPLAY_BIT:0] X,
  output logic [PIXEL_DISPLAY_BIT:0] Y,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     display_enable,
  output logic                     hsync_d,
  output logic                     vsync_d,
  output logic                     display_enable_d,
  output logic                     line_end,
  output logic                     frame_start
);

  localparam int W       = PIXEL_DISPLAY_BIT + 1;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [W-1:0] H_LAST     = W'(H_TOTAL - 1);
  localparam logic [W-1:0] V_LAST     = W'(V_TOTAL - 1);
  localparam logic [W-1:0] H_VIS      = W'(H_ACTIVE);
  localparam logic [W-1:0] V_VIS      = W'(V_ACTIVE);
  localparam logic [W-1:0] HS_START   = W'(H_ACTIVE + H_FP);
  localparam logic [W-1:0] HS_END     = W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [W-1:0] VS_START   = W'(V_ACTIVE + V_FP);
  localparam logic [W-1:0] VS_END     = W'(V_ACTIVE + V_FP + V_SYNC);

  logic [W-1:0] x_nxt;
  logic [W-1:0] y_nxt;
  logic         wrap_frame;

  always_comb begin
    x_nxt      = X + 1'b1;
    y_nxt      = Y;
    wrap_frame = 1'b0;
    if (X == H_LAST) begin
      x_nxt = '0;
      if (Y == V_LAST) begin
        y_nxt      = '0;
        wrap_frame = 1'b1;
      end else begin
        y_nxt = Y + 1'b1;
      end
    end
  end

  // Decodes use the next-state counters so they line up with X/Y after the edge.
  always_ff @(posedge clock_25 or posedge reset) begin
    if (reset) begin
      X              <= '0;
      Y              <= '0;
      hsync          <= 1'b1;
      vsync          <= 1'b1;
      display_enable <= 1'b0;
      line_end       <= 1'b0;
      frame_start    <= 1'b0;
    end else begin
      X              <= x_nxt;
      Y              <= y_nxt;
      hsync          <= !((x_nxt >= HS_START) && (x_nxt < HS_END));
      vsync          <= !((y_nxt >= VS_START) && (y_nxt < VS_END));
      display_enable <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      line_end       <= (x_nxt == H_LAST);
      frame_start    <= wrap_frame;
    end
  end

  generate
    if (SYNC_DELAY == 0) begin : g_nodelay
      assign hsync_d          = hsync;
      assign vsync_d          = vsync;
      assign display_enable_d = display_enable;
    end else begin : g_pipe
      logic [2:0] pipe [SYNC_DELAY];

      always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < SYNC_DELAY; i++) pipe[i] <= 3'b110;
        end else begin
          pipe[0] <= {hsync, vsync, display_enable};
          for (int i = 1; i < SYNC_DELAY; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign hsync_d          = pipe[SYNC_DELAY-1][2];
      assign vsync_d          = pipe[SYNC_DELAY-1][1];
      assign display_enable_d = pipe[SYNC_DELAY-1][0];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus two shrunken rasters so
// whole frames fit in a short run; a position-from-cycle-count model checks every cycle.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n;
  int   total = 0;
  int   bad   = 0;

  always #20 clk = ~clk;

  // cycles since reset release; the raster position is n mod frame length
  always @(posedge clk or posedge rst)
    if (rst) n <= 0;
    else     n <= n + 1;

  logic [9:0] xa, ya, xb, yb, xc, yc;
  logic hsa, vsa, dea, hsda, vsda, deda, lea, fsa;
  logic hsb, vsb, deb, hsdb, vsdb, dedb, leb, fsb;
  logic hsc, vsc, dec_c, hsdc, vsdc, dedc, lec, fsc;

  vga_timing_gen #(.SYNC_DELAY(1)) dut_a (
    .clock_25(clk), .reset(rst), .X(xa), .Y(ya), .hsync(hsa), .vsync(vsa),
    .display_enable(dea), .hsync_d(hsda), .vsync_d(vsda), .display_enable_d(deda),
    .line_end(lea), .frame_start(fsa));

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                   .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(0)) dut_b (
    .clock_25(clk), .reset(rst), .X(xb), .Y(yb), .hsync(hsb), .vsync(vsb),
    .display_enable(deb), .hsync_d(hsdb), .vsync_d(vsdb), .display_enable_d(dedb),
    .line_end(leb), .frame_start(fsb));

  vga_timing_gen #(.H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
                   .V_ACTIVE(10), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_DELAY(3)) dut_c (
    .clock_25(clk), .reset(rst), .X(xc), .Y(yc), .hsync(hsc), .vsync(vsc),
    .display_enable(dec_c), .hsync_d(hsdc), .vsync_d(vsdc), .display_enable_d(dedc),
    .line_end(lec), .frame_start(fsc));

  logic [27:0] act_a, act_b, act_c;
  assign act_a = {xa, ya, hsa, vsa, dea, hsda, vsda, deda, lea, fsa};
  assign act_b = {xb, yb, hsb, vsb, deb, hsdb, vsdb, dedb, leb, fsb};
  assign act_c = {xc, yc, hsc, vsc, dec_c, hsdc, vsdc, dedc, lec, fsc};

  // {hsync, vsync, display_enable} at raster position p
  function automatic logic [2:0] strobes(int p, int ha, int hf, int hs, int hb,
                                         int va, int vf, int vs);
    int ht, x, y;
    ht = ha + hf + hs + hb;
    x  = p % ht;
    y  = p / ht;
    return {!(x >= ha + hf && x < ha + hf + hs),
            !(y >= va + vf && y < va + vf + vs),
            (x < ha && y < va)};
  endfunction

  function automatic logic [27:0] model(int cyc, int ha, int hf, int hs, int hb,
                                        int va, int vf, int vs, int vb, int k);
    int ht, tot, p, m;
    logic [2:0] s, d;
    logic [9:0] x, y;
    ht  = ha + hf + hs + hb;
    tot = ht * (va + vf + vs + vb);
    if (cyc == 0) return {20'd0, 3'b110, 3'b110, 2'b00};
    p = cyc % tot;
    x = 10'(p % ht);
    y = 10'(p / ht);
    s = strobes(p, ha, hf, hs, hb, va, vf, vs);
    m = cyc - k;
    d = (m < 1) ? 3'b110 : strobes(m % tot, ha, hf, hs, hb, va, vf, vs);
    return {x, y, s, d, (p % ht == ht - 1), (p == 0)};
  endfunction

  task automatic chk(string name, logic [27:0] act, logic [27:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, n, act, exp);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, n, act, exp);
    end
  endtask

  // every-cycle comparison against the model, plus run-length monitors
  int last_fs = -1;
  int vs_low = 0;
  int hs_low = 0;
  int last_hs_fall = -1;
  logic prev_vsb = 1'b1, prev_hsa = 1'b1;

  always @(negedge clk) begin
    chk("full", act_a, model(n, 640, 16, 96, 48, 480, 10, 2, 33, 1));
    chk("small_d0", act_b, model(n, 16, 4, 6, 6, 10, 2, 2, 3, 0));
    chk("small_d3", act_c, model(n, 16, 4, 6, 6, 10, 2, 2, 3, 3));
    if (rst) begin
      last_fs = -1; vs_low = 0; hs_low = 0; last_hs_fall = -1;
      prev_vsb = 1'b1; prev_hsa = 1'b1;
    end else begin
      if (fsb) begin
        if (last_fs >= 0) chk_int("frame_interval", n - last_fs, 544);
        last_fs = n;
      end
      if (!vsb) vs_low++;
      if (vsb && !prev_vsb) begin
        chk_int("vsync_low_len", vs_low, 64);
        vs_low = 0;
      end
      if (!hsa) hs_low++;
      if (hsa && !prev_hsa) begin
        chk_int("hsync_low_len", hs_low, 96);
        hs_low = 0;
      end
      if (!hsa && prev_hsa) begin
        if (last_hs_fall >= 0) chk_int("hsync_period", n - last_hs_fall, 800);
        last_hs_fall = n;
      end
      prev_vsb = vsb;
      prev_hsa = hsa;
    end
  end

  task automatic at(int t);
    int guard;
    guard = 0;
    while (n < t && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (n != t) chk_int("reach_cycle", n, t);
  endtask

  task automatic check_reset_vals(string tag);
    chk_int({tag, "_x"}, int'(xa), 0);
    chk_int({tag, "_y"}, int'(ya), 0);
    chk_int({tag, "_hs"}, int'(hsa), 1);
    chk_int({tag, "_vs"}, int'(vsa), 1);
    chk_int({tag, "_de"}, int'(dea), 0);
    chk_int({tag, "_le"}, int'(lea), 0);
    chk_int({tag, "_fs"}, int'(fsa), 0);
    chk_int({tag, "_de_d"}, int'(deda), 0);
    chk_int({tag, "_small_x"}, int'(xb), 0);
    chk_int({tag, "_small_de_d3"}, int'(dedc), 0);
    chk_int({tag, "_small_hs_d3"}, int'(hsdc), 1);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst = 1'b0;
    @(negedge clk);
    chk_int("first_x", int'(xa), 1);
    chk_int("first_y", int'(ya), 0);
    chk_int("first_de", int'(dea), 1);

    at(303);  chk_int("small_de_15_9", int'(deb), 1);
    at(304);  chk_int("small_de_16_9", int'(deb), 0);
    at(320);  chk_int("small_de_0_10", int'(deb), 0);
    at(543);  chk_int("small_le_last", int'(leb), 1);
              chk_int("small_fs_before", int'(fsb), 0);
    at(544);  chk_int("small_fs_wrap", int'(fsb), 1);
              chk_int("small_wrap_xy", int'({xb, yb}), 0);
    at(545);  chk_int("small_fs_once", int'(fsb), 0);
    at(639);  chk_int("de_639", int'(dea), 1);
    at(640);  chk_int("de_640", int'(dea), 0);
    at(655);  chk_int("hs_655", int'(hsa), 1);
    at(656);  chk_int("hs_656", int'(hsa), 0);
    at(751);  chk_int("hs_751", int'(hsa), 0);
    at(752);  chk_int("hs_752", int'(hsa), 1);
    at(799);  chk_int("le_799", int'(lea), 1);
    at(800);  chk_int("wrap_x", int'(xa), 0);
              chk_int("wrap_y", int'(ya), 1);
              chk_int("le_after", int'(lea), 0);

    // mid-line / mid-frame asynchronous reset: full raster at (300,2), small at (12,8)
    at(1900);
    chk_int("pre_rst_x", int'(xa), 300);
    chk_int("pre_rst_small_y", int'(yb), 8);
    #2 rst = 1'b1;
    #1 check_reset_vals("async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_int("rel_x", int'(xa), 1);
    chk_int("rel_y", int'(ya), 0);
    chk_int("rel_de", int'(dea), 1);

    at(1200);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
